// File: rtl/network_tx_frame_hcp_pkg.sv
// hcp_tx_pkg: shared types and constants for the HCP transmit framer.
//   tx_state_e    framer FSM states
//   fifo_entry_t  FIFO entry {sof, eof, data[7:0]}
//   PREAMBLE_BYTE, SFD_BYTE, ERR_BYTE  fixed line bytes
package hcp_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StSfd,
    StData,
    StIfg
  } tx_state_e;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam logic [7:0] ERR_BYTE      = 8'h00;

  typedef struct packed {
    logic       sof;
    logic       eof;
    logic [7:0] data;
  } fifo_entry_t;

  localparam int unsigned EntryW = $bits(fifo_entry_t);

endpackage

// File: rtl/network_tx_frame_hcp_fifo.sv
// hcp_sync_fifo: synchronous show-ahead FIFO. The head entry is always visible on
// 'head' while 'empty' is low; 'pop' consumes it. A push while full is accepted
// when a pop happens in the same cycle.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   push        write push_data (ignored when full without a concurrent pop)
//   push_data   entry to write
//   pop         consume the head entry (ignored when empty)
//   head        current head entry
//   full, empty occupancy flags
module hcp_sync_fifo #(
  parameter int unsigned Width = 10,
  parameter int unsigned AddrW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned Depth = 1 << AddrW;

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AddrW + 1)'(Depth));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{AddrW{1'b0}}, do_push} - {{AddrW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/network_tx_frame_hcp.sv
// network_tx_frame_hcp: HCP egress transmit framer. Delimits the 9-bit input byte
// stream into frames, buffers them in a FIFO and emits preamble, SFD, data and a
// programmable inter-frame gap on a GMII-style byte interface.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   iv_pkt_data[8:0]        [8]=sof on first byte, [7:0]=byte
//   i_pkt_data_wr           input byte valid
//   ov_txd, o_tx_en, o_tx_er registered line outputs
//   o_busy                  framer not idle
//   o_fifo_overflow_pulse   one pulse at the start of each dropped burst
//   ov_frame_cnt, ov_ts_cnt, ov_err_cnt  statistics (need HCP_TX_STAT_EN, else 0)
// Build option: define HCP_TX_STAT_EN to compile in the statistics counters.
module network_tx_frame_hcp
  import hcp_tx_pkg::*;
#(
  parameter int unsigned FIFO_AW      = 5,
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned IFG_CYCLES   = 12,
  parameter int unsigned CNT_W        = 16,
  parameter logic [2:0]  TS_TYPE_MAX  = 3'h2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [8:0]       iv_pkt_data,
  input  logic             i_pkt_data_wr,
  output logic [7:0]       ov_txd,
  output logic             o_tx_en,
  output logic             o_tx_er,
  output logic             o_busy,
  output logic             o_fifo_overflow_pulse,
  output logic [CNT_W-1:0] ov_frame_cnt,
  output logic [CNT_W-1:0] ov_ts_cnt,
  output logic [CNT_W-1:0] ov_err_cnt
);

  // Input delimiter: a byte is pushed one cycle late, once the following cycle
  // shows whether it was the last byte of its frame.
  logic        hold_valid_q;
  logic [8:0]  hold_q;
  logic        drop_q, drop_d;
  logic        ovf_q, ovf_d;
  logic        push, pop;
  fifo_entry_t push_entry, head;
  logic        full, empty;

  tx_state_e   state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  txd_q, txd_d;
  logic        en_q, en_d, er_q, er_d, busy_q;
  logic        frame_done, frame_abort, first_pop;

  hcp_sync_fifo #(
    .Width (EntryW),
    .AddrW (FIFO_AW)
  ) u_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    push_entry.sof  = hold_q[8];
    push_entry.eof  = !i_pkt_data_wr || iv_pkt_data[8];
    push_entry.data = hold_q[7:0];
    push            = 1'b0;
    drop_d          = drop_q;
    ovf_d           = 1'b0;
    // In drop mode only a new sof may leave it.
    if (hold_valid_q && !(drop_q && !hold_q[8])) begin
      if (full && !pop) begin
        ovf_d  = 1'b1;
        drop_d = 1'b1;
      end else begin
        push   = 1'b1;
        drop_d = 1'b0;
      end
    end
  end

  // Next-state and next-output: state_q names what is on the line this cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    txd_d       = 8'h00;
    en_d        = 1'b0;
    er_d        = 1'b0;
    pop         = 1'b0;
    frame_done  = 1'b0;
    frame_abort = 1'b0;
    first_pop   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          if (head.sof) begin
            state_d = StPre;
            txd_d   = PREAMBLE_BYTE;
            en_d    = 1'b1;
            cnt_d   = 8'd1;
          end else begin
            pop = 1'b1;  // orphan byte with no frame start
          end
        end
      end
      StPre: begin
        en_d = 1'b1;
        if (cnt_q >= 8'(PREAMBLE_LEN)) begin
          state_d = StSfd;
          txd_d   = SFD_BYTE;
        end else begin
          txd_d = PREAMBLE_BYTE;
          cnt_d = cnt_q + 8'd1;
        end
      end
      StSfd, StData: begin
        en_d = 1'b1;
        // The head is the frame's own sof byte only right after SFD.
        if (empty || (state_q == StData && head.sof)) begin
          txd_d       = ERR_BYTE;
          er_d        = 1'b1;
          state_d     = StIfg;
          cnt_d       = 8'd0;
          frame_abort = 1'b1;
        end else begin
          pop       = 1'b1;
          first_pop = (state_q == StSfd);
          txd_d     = head.data;
          state_d   = StData;
          if (head.eof) begin
            state_d    = StIfg;
            cnt_d      = 8'd0;
            frame_done = 1'b1;
          end
        end
      end
      StIfg: begin
        if (cnt_q >= 8'(IFG_CYCLES - 1)) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
      drop_q       <= 1'b0;
      ovf_q        <= 1'b0;
      state_q      <= StIdle;
      cnt_q        <= '0;
      txd_q        <= '0;
      en_q         <= 1'b0;
      er_q         <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      hold_valid_q <= i_pkt_data_wr;
      hold_q       <= iv_pkt_data;
      drop_q       <= drop_d;
      ovf_q        <= ovf_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      txd_q        <= txd_d;
      en_q         <= en_d;
      er_q         <= er_d;
      busy_q       <= (state_d != StIdle);
    end
  end

  assign ov_txd                = txd_q;
  assign o_tx_en               = en_q;
  assign o_tx_er               = er_q;
  assign o_busy                = busy_q;
  assign o_fifo_overflow_pulse = ovf_q;

`ifdef HCP_TX_STAT_EN
  logic [CNT_W-1:0] frame_cnt_q, ts_cnt_q, err_cnt_q;
  logic             ts_flag_q, ts_first, ts_hit;

  assign ts_first = (head.data[7:5] <= TS_TYPE_MAX);
  // A one-byte frame completes on its first pop, before ts_flag_q is loaded.
  assign ts_hit   = first_pop ? ts_first : ts_flag_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      frame_cnt_q <= '0;
      ts_cnt_q    <= '0;
      err_cnt_q   <= '0;
      ts_flag_q   <= 1'b0;
    end else begin
      if (first_pop)            ts_flag_q   <= ts_first;
      if (frame_done)           frame_cnt_q <= frame_cnt_q + 1'b1;
      if (frame_done && ts_hit) ts_cnt_q    <= ts_cnt_q + 1'b1;
      if (frame_abort)          err_cnt_q   <= err_cnt_q + 1'b1;
    end
  end

  assign ov_frame_cnt = frame_cnt_q;
  assign ov_ts_cnt    = ts_cnt_q;
  assign ov_err_cnt   = err_cnt_q;
`else
  logic unused_stat;
  assign unused_stat  = ^{frame_done, frame_abort, first_pop, TS_TYPE_MAX};
  assign ov_frame_cnt = '0;
  assign ov_ts_cnt    = '0;
  assign ov_err_cnt   = '0;
`endif

endmodule

// File: doc/network_tx_frame_hcp.md
# network_tx_frame_hcp

Single-clock, parametrised transmit framer for the HCP network egress path. It accepts the 9-bit byte stream from the output-control stage and inserts preamble and SFD on a GMII-style byte interface. It enforces a programmable inter-frame gap, buffers data in a sync FIFO, and detects overflow and underrun. It also keeps optional per-class transmit statistics, generalising the fixed TS debug counter.

## Interface
- FIFO_AW, 5 — FIFO address width; depth 2^FIFO_AW entries of 10 bits (data, sof, eof)
- PREAMBLE_LEN, 7 — number of 0x55 bytes before SFD (1..15)
- IFG_CYCLES, 12 — idle cycles after each frame or abort (1..255)
- CNT_W, 16 — statistics counter width
- TS_TYPE_MAX, 3'h2 — frames whose first byte [7:5] ≤ this value count as TS frames

Ports:
- i_clk  in  1  sole clock; every register is clocked on its rising edge
- i_rst  in  1  synchronous, active-high reset
- iv_pkt_data  in  9  [8]=start-of-frame flag on first byte, [7:0]=byte
- i_pkt_data_wr  in  1  byte valid; a frame ends on the last valid byte before wr drops or before the next sof
- ov_txd  out  8  transmit byte
- o_tx_en  out  1  transmit enable
- o_tx_er  out  1  transmit error
- o_busy  out  1  FSM not in IDLE
- o_fifo_overflow_pulse  out  1  one-cycle pulse per dropped byte burst start
- ov_frame_cnt  out  CNT_W  frames sent complete
- ov_ts_cnt  out  CNT_W  TS frames sent complete
- ov_err_cnt  out  CNT_W  frames aborted

## Operation
- Input stage: one-cycle holding register. It pushes the previous byte with eof=1 when the current cycle has wr=0 or sof=1, and otherwise pushes it with eof=0.
- Push while FIFO full: the byte is dropped, `o_fifo_overflow_pulse` fires, and drop mode is set. Drop mode discards all bytes up to the next sof, which is then accepted if space exists.
- FSM states IDLE, PRE, SFD, DATA, IFG:
  - IDLE→PRE when the FIFO is non-empty and its head has sof=1. A non-sof head in IDLE is popped and discarded (orphan).
  - PRE outputs 0x55 for PREAMBLE_LEN cycles, then goes to SFD.
  - SFD outputs 0xD5 for one cycle, then goes to DATA.
  - DATA pops one byte per cycle and outputs it. On a popped byte with eof=1 it goes to IFG and the frame counts as complete.
  - DATA abort conditions: FIFO empty, or the head has sof=1 without a prior eof. On abort the head is not popped; output is tx_en=1, tx_er=1, txd=0x00 for one cycle; the FSM goes to IFG and err_cnt increments.
  - IFG holds tx_en=0 for IFG_CYCLES cycles, then goes to IDLE.
- TS classification uses the first data byte popped in DATA: bits [7:5] ≤ TS_TYPE_MAX. ts_cnt increments only when that frame completes.
- Counters wrap modulo 2^CNT_W.
- Simultaneous push and pop when full: the pop frees space and the push is accepted with no overflow.

## Timing
- All outputs are registered.
- Reset values: ov_txd=0, o_tx_en=0, o_tx_er=0, o_busy=0, o_fifo_overflow_pulse=0, all counters 0. Reset also sets FIFO empty, clears drop mode, and puts the FSM in IDLE.
- Reset mid-frame: output returns to idle on the next cycle, and the partial frame is lost without counting.
- Latency: with a sof byte presented at cycle t, the first 0x55 appears at t+3, SFD at t+3+PREAMBLE_LEN, and the first data byte at t+4+PREAMBLE_LEN.
- Back-to-back input frames accumulate PREAMBLE_LEN+1+IFG_CYCLES bytes per frame. Sustained back-to-back traffic therefore overflows eventually, which is by design.
- The overflow pulse is asserted the cycle after the rejected push.

## Configuration
- HCP_TX_STAT_EN defined: the three counters and TS classification logic are compiled in.
- HCP_TX_STAT_EN undefined: the counters are absent, ov_frame_cnt, ov_ts_cnt and ov_err_cnt are tied to 0, and framing behaviour is identical.

## Structure
- Package hcp_tx_pkg holds:
  - the state enum (IDLE, PRE, SFD, DATA, IFG)
  - constants PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, ERR_BYTE=8'h00
  - the FIFO entry struct {sof, eof, data[7:0]}
- One sub-module, hcp_sync_fifo: parametrised width/depth, registered-output show-ahead, with full, empty and simultaneous push/pop support.
- Framer FSM, input delimiter and counters live in the top.

## Test plan
- Single 64-byte frame, first byte 9'h140 (type 2), defaults → 7×0x55 at t+3..t+9, 0xD5 at t+10, data t+11..t+74, tx_en low for 12 cycles after; frame_cnt=1, ts_cnt=1, err_cnt=0.
- Two 64-byte frames separated by one idle cycle → second preamble starts exactly 12 cycles after first frame's last byte; no overflow; frame_cnt=2.
- FIFO_AW=3, 40-byte frame → overflow pulse once; tx emits one tx_er cycle (txd=0x00) when FIFO drains; err_cnt=1, frame_cnt=0; next frame after idle transmits cleanly.
- Frame with first byte [7:5]=3'h5 → frame_cnt increments, ts_cnt unchanged.
- Assert i_rst during DATA → next cycle tx_en=0, all counters 0, FSM IDLE; a subsequent frame transmits with nominal latency.
- Build without HCP_TX_STAT_EN, repeat scenario 1 → identical ov_txd/o_tx_en trace, counters read 0.
